crash_detect: RTL and testbench

Per-frame collision detector for the two light-cycles. On each `frame_clk` rising edge during play, it reads the trail RAM at each bike's next cell and decides whether either bike crashes. It then writes the surviving bikes' trail cells and emits one-cycle `red_hit`/`blue_hit` pulses. It sits directly upstream of the score/round logic, which consumes those pulses to award points and end rounds.

---
 rtl/tron_pkg.sv | 25 ++
 rtl/crash_detect_next_cell.sv | 42 ++++
 rtl/crash_detect.sv | 150 +++++++++++++++
 tb/tb_crash_detect.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle game blocks.
package tron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_R   = 3'd1,
    ST_RD_B   = 3'd2,
    ST_CAP_B  = 3'd3,
    ST_DECIDE = 3'd4,
    ST_WR_R   = 3'd5,
    ST_WR_B   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [2:0] GAME_PLAY  = 3'd1;
  localparam logic [7:0] CELL_EMPTY = 8'h00;

  localparam int unsigned ADDR_W = 15;

endpackage

// File: rtl/crash_detect_next_cell.sv
// Combinational next-cell step: moved head, grid-edge flag and linear trail address.
module next_cell
  import tron_pkg::*;
#(
  parameter int unsigned GRID_W = 160,
  parameter int unsigned GRID_H = 120
) (
  input  logic [7:0]        i_x,
  input  logic [7:0]        i_y,
  input  logic [1:0]        i_dir,
  output logic [7:0]        o_nx,
  output logic [7:0]        o_ny,
  output logic              o_oob,
  output logic [ADDR_W-1:0] o_addr
);

  always_comb begin
    o_nx  = i_x;
    o_ny  = i_y;
    o_oob = 1'b0;
    case (i_dir)
      DIR_UP: begin
        o_ny  = i_y - 8'd1;
        o_oob = (i_y == 8'd0);
      end
      DIR_RIGHT: begin
        o_nx  = i_x + 8'd1;
        o_oob = (32'(i_x) == GRID_W - 1);
      end
      DIR_DOWN: begin
        o_ny  = i_y + 8'd1;
        o_oob = (32'(i_y) == GRID_H - 1);
      end
      default: begin
        o_nx  = i_x - 8'd1;
        o_oob = (i_x == 8'd0);
      end
    endcase
    o_addr = ADDR_W'(o_ny) * ADDR_W'(GRID_W) + ADDR_W'(o_nx);
  end

endmodule

// File: rtl/crash_detect.sv
// Per-frame collision detector: reads both bikes' next cells, decides crashes,
// writes surviving trails and pulses red_hit/blue_hit with step_done.
module crash_detect
  import tron_pkg::*;
#(
  parameter int unsigned GRID_W     = 160,
  parameter int unsigned GRID_H     = 120,
  parameter logic [7:0]  RED_COLOR  = 8'h01,
  parameter logic [7:0]  BLUE_COLOR = 8'h02
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic [2:0]          Game_State,
  input  logic [7:0]          Red_X,
  input  logic [7:0]          Red_Y,
  input  logic [7:0]          Blue_X,
  input  logic [7:0]          Blue_Y,
  input  logic [1:0]          Red_dir,
  input  logic [1:0]          Blue_dir,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic [7:0]          mem_wdata,
  output logic                mem_we,
  output logic                busy,
  output logic                step_done,
  output logic                red_hit,
  output logic                blue_hit
);

  if (GRID_W * GRID_H > 32768) begin : g_area_chk
    $error("crash_detect: GRID_W*GRID_H does not fit a 15-bit address");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_frame_q;
  logic [7:0]          r_red_x, r_red_y, r_blue_x, r_blue_y;
  logic [1:0]          r_red_dir, r_blue_dir;
  logic [7:0]          r_red_data, r_blue_data;
  logic                r_red_crash, r_blue_crash;

  logic                w_start;
  logic [7:0]          w_red_nx, w_red_ny, w_blue_nx, w_blue_ny;
  logic                w_red_oob, w_blue_oob;
  logic [ADDR_W-1:0]   w_red_addr, w_blue_addr;
  logic                w_same_cell, w_red_crash, w_blue_crash;

  next_cell #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_red_next (
    .i_x(r_red_x), .i_y(r_red_y), .i_dir(r_red_dir),
    .o_nx(w_red_nx), .o_ny(w_red_ny), .o_oob(w_red_oob), .o_addr(w_red_addr)
  );

  next_cell #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_blue_next (
    .i_x(r_blue_x), .i_y(r_blue_y), .i_dir(r_blue_dir),
    .o_nx(w_blue_nx), .o_ny(w_blue_ny), .o_oob(w_blue_oob), .o_addr(w_blue_addr)
  );

  assign w_start      = frame_clk && !r_frame_q && (r_state == ST_IDLE) && (Game_State == GAME_PLAY);
  assign w_same_cell  = (w_red_nx == w_blue_nx) && (w_red_ny == w_blue_ny);
  assign w_red_crash  = w_red_oob  || (r_red_data  != CELL_EMPTY) || w_same_cell;
  assign w_blue_crash = w_blue_oob || (r_blue_data != CELL_EMPTY) || w_same_cell;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving PLAY mid-evaluation abandons it without writes or pulses.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state != ST_IDLE) && (Game_State != GAME_PLAY)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start) w_state_nxt = ST_RD_R;
        ST_RD_R:   w_state_nxt = ST_RD_B;
        ST_RD_B:   w_state_nxt = ST_CAP_B;
        ST_CAP_B:  w_state_nxt = ST_DECIDE;
        ST_DECIDE: w_state_nxt = ST_WR_R;
        ST_WR_R:   w_state_nxt = ST_WR_B;
        ST_WR_B:   w_state_nxt = ST_DONE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_frame_q    <= 1'b0;
      r_red_x      <= 8'd0;
      r_red_y      <= 8'd0;
      r_blue_x     <= 8'd0;
      r_blue_y     <= 8'd0;
      r_red_dir    <= 2'd0;
      r_blue_dir   <= 2'd0;
      r_red_data   <= 8'd0;
      r_blue_data  <= 8'd0;
      r_red_crash  <= 1'b0;
      r_blue_crash <= 1'b0;
    end else begin
      r_frame_q <= frame_clk;
      if (w_start) begin
        r_red_x    <= Red_X;
        r_red_y    <= Red_Y;
        r_blue_x   <= Blue_X;
        r_blue_y   <= Blue_Y;
        r_red_dir  <= Red_dir;
        r_blue_dir <= Blue_dir;
      end
      // RAM data lags the address by one cycle.
      if (r_state == ST_RD_B)   r_red_data  <= w_red_oob  ? CELL_EMPTY : mem_rdata;
      if (r_state == ST_CAP_B)  r_blue_data <= w_blue_oob ? CELL_EMPTY : mem_rdata;
      if (r_state == ST_DECIDE) begin
        r_red_crash  <= w_red_crash;
        r_blue_crash <= w_blue_crash;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = CELL_EMPTY;
    mem_we    = 1'b0;
    case (r_state)
      ST_RD_R: mem_addr = w_red_oob  ? '0 : w_red_addr;
      ST_RD_B: mem_addr = w_blue_oob ? '0 : w_blue_addr;
      ST_WR_R: if (!r_red_crash) begin
        mem_addr  = w_red_addr;
        mem_wdata = RED_COLOR;
        mem_we    = 1'b1;
      end
      ST_WR_B: if (!r_blue_crash) begin
        mem_addr  = w_blue_addr;
        mem_wdata = BLUE_COLOR;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign step_done = (r_state == ST_DONE);
  assign red_hit   = step_done && r_red_crash;
  assign blue_hit  = step_done && r_blue_crash;

endmodule

// File: tb/tb_crash_detect.sv
// Scoreboard bench for crash_detect: stimulus queues expected RAM reads,
// writes and result pulses; a negedge monitor pops and compares them.
module tb_crash_detect;
  import tron_pkg::*;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_DN = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [2:0]  Game_State;
  logic [7:0]  Red_X, Red_Y, Blue_X, Blue_Y;
  logic [1:0]  Red_dir, Blue_dir;
  logic [14:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        mem_we, busy, step_done, red_hit, blue_hit;

  crash_detect dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
    .Red_X(Red_X), .Red_Y(Red_Y), .Blue_X(Blue_X), .Blue_Y(Blue_Y),
    .Red_dir(Red_dir), .Blue_dir(Blue_dir),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .step_done(step_done), .red_hit(red_hit), .blue_hit(blue_hit)
  );

  always #5 Clk = ~Clk;

  logic [7:0] ram [0:32767];

  always @(posedge Clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  typedef struct {
    int kind;
    int a;
    int d;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic observe(input int kind, input int a, input int d, input int cyc);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%0d cyc=%0d, required no event",
               kind, a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.a != a || e.d != d || e.cyc != cyc) begin
      n_fail++;
      $display("FAIL scoreboard: got kind=%0d addr=%0d data=%0d cyc=%0d, required kind=%0d addr=%0d data=%0d cyc=%0d",
               kind, a, d, cyc, e.kind, e.a, e.d, e.cyc);
    end
  endtask

  // Cycle index 1 = RD_R; reads at 1/2, writes at 5/6, result at 7.
  initial begin : monitor
    int cyc;
    cyc = 0;
    forever begin
      @(negedge Clk);
      if (busy) cyc++; else cyc = 0;
      if (busy && (cyc == 1 || cyc == 2)) observe(K_RD, int'(mem_addr), 0, cyc);
      if (mem_we) observe(K_WR, int'(mem_addr), int'(mem_wdata), cyc);
      if (step_done || red_hit || blue_hit)
        observe(K_DN, 0, int'({step_done, red_hit, blue_hit}), cyc);
    end
  end

  task automatic push(input int kind, input int a, input int d, input int cyc);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic exp_reads(input int ra, input int ba);
    push(K_RD, ra, 0, 1);
    push(K_RD, ba, 0, 2);
  endtask

  task automatic exp_eval(input int ra, input int ba, input int wra, input int wba,
                          input bit rh, input bit bh);
    exp_reads(ra, ba);
    if (!rh) push(K_WR, wra, 1, 5);
    if (!bh) push(K_WR, wba, 2, 6);
    push(K_DN, 0, int'({1'b1, rh, bh}), 7);
  endtask

  task automatic set_bikes(input int rx, input int ry, input int rd,
                           input int bx, input int by, input int bd);
    Red_X = 8'(rx);  Red_Y = 8'(ry);  Red_dir = 2'(rd);
    Blue_X = 8'(bx); Blue_Y = 8'(by); Blue_dir = 2'(bd);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
  endtask

  task automatic frame_pulse();
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; Game_State = 3'd1;
    set_bikes(0, 0, 0, 0, 0, 0);
    clear_ram();
    idle_wait(3);
    check("rst_mem_addr",  int'(mem_addr),  0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_mem_we",    int'(mem_we),    0);
    check("rst_busy",      int'(busy),      0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_red_hit",   int'(red_hit),   0);
    check("rst_blue_hit",  int'(blue_hit),  0);
    Reset = 1'b0;
    idle_wait(2);

    // Both survive: red (10,10)R -> 1611, blue (50,50)U -> (50,49) = 7890.
    set_bikes(10, 10, 1, 50, 50, 0);
    exp_eval(1611, 7890, 1611, 7890, 1'b0, 1'b0);
    frame_pulse();
    idle_wait(10);
    check("ram_red_1611",  int'(ram[1611]), 1);
    check("ram_blue_7890", int'(ram[7890]), 2);

    // Red at right edge; blue normal.
    clear_ram();
    set_bikes(159, 10, 1, 50, 50, 0);
    exp_eval(0, 7890, 0, 7890, 1'b1, 1'b0);
    frame_pulse();
    idle_wait(10);

    // Blue runs into existing red trail at (30,31) = 4990; red (5,5)L -> 804.
    clear_ram();
    ram[4990] = 8'h01;
    set_bikes(5, 5, 3, 30, 30, 2);
    exp_eval(804, 4990, 804, 4990, 1'b0, 1'b1);
    frame_pulse();
    idle_wait(10);
    check("ram_blue_blocked", int'(ram[4990]), 1);

    // Head-on into (21,20) = 3221.
    clear_ram();
    set_bikes(20, 20, 1, 22, 20, 3);
    exp_eval(3221, 3221, 0, 0, 1'b1, 1'b1);
    frame_pulse();
    idle_wait(10);

    // Left edge and bottom edge.
    set_bikes(0, 7, 3, 40, 119, 2);
    exp_eval(0, 0, 0, 0, 1'b1, 1'b1);
    frame_pulse();
    idle_wait(10);

    // Top edge; blue (159,60)L -> (158,60) = 9758.
    clear_ram();
    set_bikes(3, 0, 0, 159, 60, 3);
    exp_eval(0, 9758, 0, 9758, 1'b1, 1'b0);
    frame_pulse();
    idle_wait(10);
    check("ram_blue_9758", int'(ram[9758]), 2);

    // Edge outside PLAY is ignored.
    clear_ram();
    Game_State = 3'd4;
    set_bikes(10, 10, 1, 50, 50, 0);
    frame_pulse();
    idle_wait(10);
    check("no_play_busy", int'(busy), 0);

    // Second edge during evaluation is dropped.
    Game_State = 3'd1;
    exp_eval(1611, 7890, 1611, 7890, 1'b0, 1'b0);
    frame_pulse();
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
    idle_wait(12);

    // Leaving PLAY during CAP_B aborts: IDLE next cycle, no writes/pulses.
    clear_ram();
    exp_reads(1611, 7890);
    frame_pulse();
    @(negedge Clk);
    @(negedge Clk); Game_State = 3'd4;
    @(negedge Clk);
    check("abort_busy", int'(busy), 0);
    idle_wait(10);
    check("abort_no_write", int'(ram[1611]), 0);
    Game_State = 3'd1;

    // Reset during WR_R cancels the write at once.
    clear_ram();
    exp_reads(1611, 7890);
    frame_pulse();
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    #1;
    check("wr_r_we_before_reset", int'(mem_we), 1);
    check("wr_r_addr_before_reset", int'(mem_addr), 1611);
    Reset = 1'b1;
    #1;
    check("midrst_mem_we",    int'(mem_we),    0);
    check("midrst_mem_addr",  int'(mem_addr),  0);
    check("midrst_mem_wdata", int'(mem_wdata), 0);
    check("midrst_busy",      int'(busy),      0);
    check("midrst_step_done", int'(step_done), 0);
    @(negedge Clk); Reset = 1'b0;
    idle_wait(10);
    check("midrst_no_write", int'(ram[1611]), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
